// File: rtl/rob_sn_allocator.sv
// In-order sequence-number allocator for the ROB: grants SNs, validates out-of-order
// completions (zero-latency passthrough to ROB insert), recycles on retire, drain-style flush.
module rob_sn_allocator #(
  parameter int p_depth    = 8,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_bitwidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_en_i,
  output logic                  alloc_cpl_o,
  output logic [p_ptrwidth-1:0] alloc_sn_o,
  input  logic                  cmpl_en_i,
  input  logic [p_ptrwidth-1:0] cmpl_sn_i,
  input  logic [p_bitwidth-1:0] cmpl_data_i,
  output logic                  cmpl_cpl_o,
  output logic                  ins_en_o,
  input  logic                  ins_cpl_i,
  output logic [p_ptrwidth-1:0] ins_sn_o,
  output logic [p_bitwidth-1:0] ins_data_o,
  input  logic                  retire_en_i,
  input  logic                  flush_en_i,
  output logic                  flush_cpl_o,
  output logic [p_ptrwidth:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [p_ptrwidth:0] DepthC = p_depth[p_ptrwidth:0];

  logic [p_ptrwidth-1:0] head_q, head_d, tail_q, tail_d;
  logic [p_ptrwidth:0]   count_q, count_d;
  logic [p_depth-1:0]    out_vld_q, out_vld_d, done_q, done_d;
  logic [1:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic                  sn_live, alloc_ok, retire_ok;

  assign full_o   = (count_q == DepthC);
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign err_o    = err_q;
  assign flush_cpl_o = (state_q == DONE);

  // Gated by rst_ni so the grant cannot glitch high while reset holds state at RUN.
  assign alloc_ok    = rst_ni & alloc_en_i & ~full_o & (state_q == RUN) & ~flush_en_i;
  assign alloc_cpl_o = alloc_ok;
  assign alloc_sn_o  = tail_q;

  assign sn_live    = out_vld_q[cmpl_sn_i] & ~done_q[cmpl_sn_i];
  assign ins_en_o   = cmpl_en_i & sn_live;
  assign cmpl_cpl_o = ins_en_o & ins_cpl_i;
  assign ins_sn_o   = rst_ni ? cmpl_sn_i : '0;
  assign ins_data_o = rst_ni ? cmpl_data_i : '0;

  assign retire_ok = retire_en_i & ~empty_o;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    out_vld_d = out_vld_q;
    done_d    = done_q;
    state_d   = state_q;
    err_d     = (cmpl_en_i & ~sn_live) | (retire_en_i & empty_o);

    if (cmpl_cpl_o) done_d[cmpl_sn_i] = 1'b1;
    if (retire_ok) begin
      out_vld_d[head_q] = 1'b0;
      done_d[head_q]    = 1'b0;
      head_d            = head_q + 1'b1;
    end
    if (alloc_ok) begin
      out_vld_d[tail_q] = 1'b1;
      done_d[tail_q]    = 1'b0;
      tail_d            = tail_q + 1'b1;
    end

    if (alloc_ok && !retire_ok)      count_d = count_q + 1'b1;
    else if (!alloc_ok && retire_ok) count_d = count_q - 1'b1;

    case (state_q)
      RUN:   if (flush_en_i) state_d = DRAIN;
      DRAIN: if (count_q == '0) state_d = DONE;
      DONE: begin
        // SN space is empty here, so restarting both pointers at 0 is safe.
        head_d  = '0;
        tail_d  = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_vld_q <= '0;
      done_q    <= '0;
      state_q   <= RUN;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      done_q    <= done_d;
      state_q   <= state_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rob_sn_allocator.sv
// Directed scenarios plus random traffic against a queue-based model of the SN allocator.
module tb_rob_sn_allocator;
  localparam int D = 8;
  localparam int PW = 3;
  localparam int BW = 8;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic alloc_en_i = 0, cmpl_en_i = 0, ins_cpl_i = 0, retire_en_i = 0, flush_en_i = 0;
  logic [PW-1:0] cmpl_sn_i = '0;
  logic [BW-1:0] cmpl_data_i = '0;
  logic alloc_cpl_o, cmpl_cpl_o, ins_en_o, flush_cpl_o, full_o, empty_o, err_o;
  logic [PW-1:0] alloc_sn_o, ins_sn_o;
  logic [BW-1:0] ins_data_o;
  logic [PW:0] count_o;

  int checks = 0, failures = 0;

  // Model: outstanding SNs in allocation order, per-SN completion flag, flush phase.
  int  oq[$];
  bit  mdone[D];
  int  next_sn;
  int  mst;      // 0 run, 1 draining, 2 flush finishing
  bit  merr;

  rob_sn_allocator #(.p_depth(D), .p_ptrwidth(PW), .p_bitwidth(BW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_en_i(alloc_en_i), .alloc_cpl_o(alloc_cpl_o), .alloc_sn_o(alloc_sn_o),
    .cmpl_en_i(cmpl_en_i), .cmpl_sn_i(cmpl_sn_i), .cmpl_data_i(cmpl_data_i),
    .cmpl_cpl_o(cmpl_cpl_o), .ins_en_o(ins_en_o), .ins_cpl_i(ins_cpl_i),
    .ins_sn_o(ins_sn_o), .ins_data_o(ins_data_o),
    .retire_en_i(retire_en_i), .flush_en_i(flush_en_i), .flush_cpl_o(flush_cpl_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_live(input int sn);
    foreach (oq[i]) if (oq[i] == sn) return !mdone[sn];
    return 1'b0;
  endfunction

  task automatic model_reset();
    oq.delete();
    foreach (mdone[i]) mdone[i] = 1'b0;
    next_sn = 0;
    mst = 0;
    merr = 1'b0;
  endtask

  // One clock: drive inputs, check at negedge against the model, advance model at posedge.
  task automatic step(input bit a, input bit ce, input int csn, input int cd,
                      input bit ic, input bit re, input bit fe);
    bit e_alloc, e_ins, e_cpl, live;
    int sz;
    alloc_en_i = a; cmpl_en_i = ce; cmpl_sn_i = csn[PW-1:0]; cmpl_data_i = cd[BW-1:0];
    ins_cpl_i = ic; retire_en_i = re; flush_en_i = fe;
    sz = oq.size();
    live = is_live(csn);
    e_alloc = a && (sz < D) && (mst == 0) && !fe;
    e_ins = ce && live;
    e_cpl = e_ins && ic;
    @(negedge clk_i);
    chk("count", count_o, sz);
    chk("full", full_o, sz == D);
    chk("empty", empty_o, sz == 0);
    chk("err", err_o, merr);
    chk("flush_cpl", flush_cpl_o, mst == 2);
    chk("alloc_cpl", alloc_cpl_o, e_alloc);
    if (e_alloc) chk("alloc_sn", alloc_sn_o, next_sn);
    chk("ins_en", ins_en_o, e_ins);
    chk("cmpl_cpl", cmpl_cpl_o, e_cpl);
    if (ce) begin
      chk("ins_sn", ins_sn_o, csn);
      chk("ins_data", ins_data_o, cd);
    end
    @(posedge clk_i);
    merr = (ce && !live) || (re && sz == 0);
    if (e_cpl) mdone[csn] = 1'b1;
    if (re && sz > 0) begin
      mdone[oq[0]] = 1'b0;
      void'(oq.pop_front());
    end
    if (e_alloc) begin
      oq.push_back(next_sn);
      mdone[next_sn] = 1'b0;
      next_sn = (next_sn + 1) % D;
    end
    case (mst)
      0: if (fe) mst = 1;
      1: if (sz == 0) mst = 2;
      default: begin mst = 0; next_sn = 0; end
    endcase
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alloc(); step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic retire(); step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic cmpl(input int sn, input bit ic); step(0, 1, sn, 8'h40 + sn, ic, 0, 0); endtask

  // Asynchronous reset applied mid-cycle, checked while asserted, released off-edge.
  task automatic do_reset();
    alloc_en_i = 1; cmpl_en_i = 0; retire_en_i = 0; flush_en_i = 0; ins_cpl_i = 0;
    rst_ni = 1'b0;
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_flush_cpl", flush_cpl_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_alloc_cpl", alloc_cpl_o, 0);
    model_reset();
    alloc_en_i = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    do_reset();

    // Fill and wrap
    for (int i = 0; i < D; i++) alloc();
    alloc();
    retire(); retire();
    alloc(); alloc();

    // Out-of-order completion and duplicate
    do_reset();
    for (int i = 0; i < 4; i++) alloc();
    cmpl(2, 1); cmpl(0, 1); cmpl(3, 1); cmpl(1, 1);
    cmpl(2, 1);
    idle();

    // Backpressure on the insert port
    do_reset();
    alloc(); alloc();
    for (int i = 0; i < 3; i++) cmpl(1, 0);
    cmpl(1, 1);
    cmpl(1, 1);
    idle();

    // Alloc and retire together when full and when half full
    do_reset();
    for (int i = 0; i < D; i++) alloc();
    step(1, 0, 0, 0, 0, 1, 0);
    retire(); retire(); retire();
    step(1, 0, 0, 0, 0, 1, 0);
    idle();

    // Flush with two outstanding
    do_reset();
    alloc(); alloc();
    step(1, 0, 0, 0, 0, 0, 1);
    alloc();
    retire(); retire();
    idle(); idle(); idle();
    alloc();
    retire();
    retire();
    idle();

    // Flush with nothing outstanding
    step(0, 0, 0, 0, 0, 0, 1);
    idle(); idle(); idle();

    // Reset in the middle of a drain
    alloc(); alloc(); alloc();
    step(0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("drain_count", count_o, 3);
    do_reset();
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit a, ce, ic, re, fe;
      int csn;
      a  = ($urandom % 3) != 0;
      ce = ($urandom % 2) == 0;
      if (oq.size() > 0 && ($urandom % 5) != 0) csn = oq[$urandom % oq.size()];
      else csn = $urandom % D;
      ic = ($urandom % 4) != 0;
      re = (oq.size() > 0 && mdone[oq[0]] && ($urandom % 2) == 0) || ($urandom % 60) == 0;
      fe = ($urandom % 80) == 0;
      step(a, ce, csn, $urandom % 256, ic, re, fe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
